instr_issuer: RTL and testbench



---
 rtl/instr_issuer_if.sv | 21 ++
 rtl/instr_issuer.sv | 112 +++++++++++
 tb/tb_instr_issuer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issuer_if.sv
// Handshake and memory bus between the instruction issuer, its instruction memory and the ALU.
interface instr_issuer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [15:0]       imem_data;
  logic [15:0]       ir;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output imem_addr, imem_rd, ir, ir_valid,
    input  imem_data, ir_ready
  );

  modport slave (
    input  imem_addr, imem_rd, ir, ir_valid,
    output imem_data, ir_ready
  );
endinterface

// File: rtl/instr_issuer.sv
// Fetches instruction words by pc and issues them on ir with valid/ready,
// one per key press (step) or continuously (run), stopping on HALT_OP or end of program.
module instr_issuer #(
  parameter int         ADDR_W   = 8,
  parameter int         PROG_LEN = 16,
  parameter logic [3:0] HALT_OP  = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_key_i,
  input  logic              run_mode_i,
  instr_issuer_if.master    bus,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(PROG_LEN);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q, halted_d;
  logic              key_s1_q, key_s2_q, key_prev_q;
  logic              step_pulse;

  // Key is active-low: a press is a 1->0 transition after synchronization.
  assign step_pulse = key_prev_q & ~key_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      key_prev_q <= 1'b1;
    end else begin
      key_s1_q   <= step_key_i;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    case (state_q)
      S_IDLE: begin
        if (halted_q) begin
          state_d = S_IDLE;
        end else if (pc_q == END_PC) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (run_mode_i || step_pulse) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_data[15:12] == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          ir_d       = bus.imem_data;
          ir_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      // pc advances only on acceptance so a stalled consumer loses nothing.
      S_ISSUE: begin
        if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          pc_d       = pc_q + 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.imem_rd   = (state_q == S_FETCH);
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign pc_o          = pc_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: expected issue words are queued when memory is loaded
// and compared against every accepted handshake.
module tb_instr_issuer;
  localparam int ADDR_W   = 8;
  localparam int PROG_LEN = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              step_key = 1'b1;
  logic              run_mode = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  logic [15:0] mem [0:255];
  logic [15:0] exp_q [$];
  int          fetch_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  instr_issuer_if #(.ADDR_W(ADDR_W)) bus_if ();

  instr_issuer #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .HALT_OP(4'b1111)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_key_i (step_key),
    .run_mode_i (run_mode),
    .bus        (bus_if.master),
    .pc_o       (pc),
    .halted_o   (halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears one cycle after the read strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_if.imem_data <= 16'h0000;
      fetch_cnt        <= 0;
    end else if (bus_if.imem_rd) begin
      bus_if.imem_data <= mem[bus_if.imem_addr];
      fetch_cnt        <= fetch_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_if.ir_valid && bus_if.ir_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_issue", 32'(bus_if.ir), 32'hFFFF_FFFF);
      else chk("sb_ir", 32'(bus_if.ir), 32'(exp_q.pop_front()));
    end
  end

  task automatic load_mem(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    for (int i = 0; i < 256; i++) mem[i] = 16'h5555;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_key = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (bus_if.ir_valid) break;
    end
    chk("tmo_ir_valid", 32'(bus_if.ir_valid), 1);
  endtask

  task automatic wait_halted(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (halted) break;
    end
    chk("tmo_halted", 32'(halted), 1);
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    step_key = 1'b0;
    repeat (hold) @(negedge clk);
    step_key = 1'b1;
  endtask

  initial begin
    // Run mode with a HALT word at address 2.
    load_mem(16'h0123, 16'h1456, 16'hF000, 16'h0000);
    exp_q.push_back(16'h0123);
    exp_q.push_back(16'h1456);
    run_mode = 1'b1;
    bus_if.ir_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ir", 32'(bus_if.ir), 0);
    chk("rst_valid", 32'(bus_if.ir_valid), 0);
    chk("rst_rd", 32'(bus_if.imem_rd), 0);
    chk("rst_addr", 32'(bus_if.imem_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    do_reset();
    cycles(2);
    chk("lat_valid_edge2", 32'(bus_if.ir_valid), 0);
    cycles(1);
    chk("lat_valid_edge3", 32'(bus_if.ir_valid), 1);
    chk("lat_ir_first", 32'(bus_if.ir), 32'h0123);
    cycles(1);
    chk("valid_one_cycle", 32'(bus_if.ir_valid), 0);
    wait_halted(50);
    chk("halt_pc", 32'(pc), 2);
    chk("halt_ir_kept", 32'(bus_if.ir), 32'h1456);
    chk("halt_valid", 32'(bus_if.ir_valid), 0);
    chk("halt_fetches", 32'(fetch_cnt), 3);
    chk("halt_sb_drained", 32'(exp_q.size()), 0);

    // Step mode: a held key issues once; a second press issues the next word.
    load_mem(16'h9A12, 16'h0BCD, 16'hF000, 16'h0000);
    run_mode = 1'b0;
    do_reset();
    cycles(5);
    chk("step_idle_pc", 32'(pc), 0);
    chk("step_idle_fetch", 32'(fetch_cnt), 0);
    exp_q.push_back(16'h9A12);
    press(20);
    cycles(5);
    chk("step1_pc", 32'(pc), 1);
    chk("step1_fetches", 32'(fetch_cnt), 1);
    chk("step1_ir", 32'(bus_if.ir), 32'h9A12);
    exp_q.push_back(16'h0BCD);
    press(3);
    cycles(10);
    chk("step2_pc", 32'(pc), 2);
    chk("step2_fetches", 32'(fetch_cnt), 2);
    chk("step2_ir", 32'(bus_if.ir), 32'h0BCD);
    chk("step_sb_drained", 32'(exp_q.size()), 0);

    // Backpressure in step mode, with a press during ISSUE that must be ignored.
    load_mem(16'h2345, 16'h6789, 16'hF000, 16'h0000);
    bus_if.ir_ready = 1'b0;
    do_reset();
    exp_q.push_back(16'h2345);
    press(3);
    wait_valid(20);
    press(4);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk("bp_ir", 32'(bus_if.ir), 32'h2345);
      chk("bp_valid", 32'(bus_if.ir_valid), 1);
      chk("bp_pc", 32'(pc), 0);
    end
    @(negedge clk);
    bus_if.ir_ready = 1'b1;
    cycles(1);
    chk("bp_hs_pc", 32'(pc), 1);
    chk("bp_hs_valid", 32'(bus_if.ir_valid), 0);
    cycles(10);
    chk("bp_no_extra_fetch", 32'(fetch_cnt), 1);
    chk("bp_pc_hold", 32'(pc), 1);
    chk("bp_sb_drained", 32'(exp_q.size()), 0);

    // End of program without HALT opcode.
    load_mem(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    run_mode = 1'b1;
    bus_if.ir_ready = 1'b1;
    do_reset();
    wait_halted(100);
    chk("eop_pc", 32'(pc), 4);
    chk("eop_fetches", 32'(fetch_cnt), 4);
    chk("eop_ir_kept", 32'(bus_if.ir), 32'h4444);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk("eop_rd_low", 32'(bus_if.imem_rd), 0);
    end
    chk("eop_fetches_after", 32'(fetch_cnt), 4);
    chk("eop_pc_after", 32'(pc), 4);
    chk("eop_sb_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset while an instruction is pending.
    load_mem(16'h1111, 16'h2345, 16'h3333, 16'h4444);
    exp_q.push_back(16'h1111);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pc == 8'd1) break;
    end
    bus_if.ir_ready = 1'b0;
    chk("ar_pc_pre", 32'(pc), 1);
    wait_valid(20);
    chk("ar_ir_pre", 32'(bus_if.ir), 32'h2345);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus_if.ir_valid), 0);
    chk("ar_pc", 32'(pc), 0);
    chk("ar_ir", 32'(bus_if.ir), 0);
    chk("ar_sb_drained", 32'(exp_q.size()), 0);
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end
endmodule
